// File: rtl/trainer_pkg.sv
// Shared types and constants for the keyboard trainer sequencing logic.
package trainer_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_KEY = 2'd1,
    ERR_SHOW = 2'd2,
    DONE     = 2'd3
  } state_e;

  // PS/2 scan codes the decoder side cares about
  localparam logic [7:0] KEY_RELEASE = 8'hF0;
  localparam logic [7:0] KEY_SPACE   = 8'h29;
  localparam logic [7:0] KEY_TAB     = 8'h0D;
  localparam logic [7:0] KEY_RSHIFT  = 8'h59;
  localparam logic [7:0] KEY_NONE    = 8'h00;

  // Target text: "qwertyuiopasdfgh" as scan codes
  localparam int unsigned TEXT_LEN   = 16;
  localparam int unsigned TEXT_IDX_W = 4;
  localparam logic [7:0] TRAINER_TEXT [TEXT_LEN] = '{
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43,
    8'h44, 8'h4D, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33
  };

endpackage

// File: rtl/trainer_seq_ctrl_if.sv
// Decoder/display-facing signal bundle of the trainer sequencing controller.
interface trainer_seq_ctrl_if #(
  parameter int unsigned IDX_W = 8
);
  logic [7:0]       key_code;
  logic             key_stb;
  logic             set_in;
  logic             reset_in;
  logic [7:0]       target_code;
  logic [IDX_W-1:0] pos;
  logic [7:0]       err_cnt;
  logic             err_flash;
  logic             busy;
  logic             done;

  // Decoder / environment side
  modport master (
    output key_code, key_stb, set_in, reset_in,
    input  target_code, pos, err_cnt, err_flash, busy, done
  );

  // Controller side
  modport slave (
    input  key_code, key_stb, set_in, reset_in,
    output target_code, pos, err_cnt, err_flash, busy, done
  );
endinterface

// File: rtl/trainer_text_rom.sv
// Combinational position -> expected scan code lookup over the target text.
module trainer_text_rom
  import trainer_pkg::*;
#(
  parameter int unsigned LEN   = 16,
  parameter int unsigned IDX_W = 8
) (
  input  logic [IDX_W-1:0] pos,
  output logic [7:0]       target_code
);

  logic [TEXT_IDX_W-1:0] idx_c;

  // Positions beyond the text (or beyond the stored table) read as no key
  always_comb begin
    target_code = KEY_NONE;
    idx_c       = TEXT_IDX_W'(pos);
    if ((32'(pos) < 32'(LEN)) && (32'(pos) < 32'(TEXT_LEN))) begin
      target_code = TRAINER_TEXT[idx_c];
    end
  end

endmodule

// File: rtl/trainer_seq_ctrl.sv
// Keyboard trainer sequencer: walks the target text, counts wrong keys,
// flashes an error indication for a fixed time and reports completion.
module trainer_seq_ctrl
  import trainer_pkg::*;
#(
  parameter int unsigned LEN      = 16,
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned ERR_HOLD = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  trainer_seq_ctrl_if.slave bus
);

  localparam int unsigned HOLD_W = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ERR_HOLD - 1);
  localparam logic [IDX_W-1:0]  LAST_POS  = IDX_W'(LEN - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  pos_q, pos_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              err_flash_q, err_flash_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              set_q, set_d;
  logic              reset_in_q, reset_in_d;

  logic              set_ev_c;
  logic              reset_ev_c;
  logic              key_hit_c;
  logic [7:0]        target_code_c;

  trainer_text_rom #(
    .LEN   (LEN),
    .IDX_W (IDX_W)
  ) u_rom (
    .pos         (pos_q),
    .target_code (target_code_c)
  );

  // Rising-edge detection of the level requests; a held level fires once
  always_comb begin
    set_d      = bus.set_in;
    reset_in_d = bus.reset_in;
    set_ev_c   = bus.set_in & ~set_q;
    reset_ev_c = bus.reset_in & ~reset_in_q;
    key_hit_c  = bus.key_stb && (bus.key_code != KEY_NONE);
  end

  // Next-state and registered output computation; reset > set > key
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    err_cnt_d   = err_cnt_q;
    err_flash_d = err_flash_q;
    done_d      = done_q;
    hold_d      = hold_q;

    if (reset_ev_c) begin
      state_d     = IDLE;
      pos_d       = '0;
      err_cnt_d   = '0;
      err_flash_d = 1'b0;
      done_d      = 1'b0;
      hold_d      = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (set_ev_c) begin
            state_d   = WAIT_KEY;
            pos_d     = '0;
            err_cnt_d = '0;
            done_d    = 1'b0;
          end
        end
        WAIT_KEY: begin
          if (key_hit_c) begin
            if (bus.key_code == target_code_c) begin
              if (pos_q == LAST_POS) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                pos_d = pos_q + IDX_W'(1);
              end
            end else begin
              if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
              end
              hold_d      = HOLD_LOAD;
              err_flash_d = 1'b1;
              state_d     = ERR_SHOW;
            end
          end
        end
        ERR_SHOW: begin
          if (hold_q == '0) begin
            err_flash_d = 1'b0;
            state_d     = WAIT_KEY;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == WAIT_KEY) || (state_d == ERR_SHOW);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      err_cnt_q   <= '0;
      err_flash_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hold_q      <= '0;
      set_q       <= 1'b0;
      reset_in_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      err_cnt_q   <= err_cnt_d;
      err_flash_q <= err_flash_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hold_q      <= hold_d;
      set_q       <= set_d;
      reset_in_q  <= reset_in_d;
    end
  end

  assign bus.target_code = target_code_c;
  assign bus.pos         = pos_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.err_flash   = err_flash_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: doc/trainer_seq_ctrl.md
Name: trainer_seq_ctrl

Overview:
Sequencing controller for the keyboard trainer, sitting between the PS/2 scan-code decoder and the display logic.
- Consumes decoded key codes plus the set (space) and reset (tab / right-shift) requests.
- Walks a fixed target text one character at a time and compares each typed key with the expected scan code.
- Counts errors, holds an error indication for a fixed time, and reports completion.

Parameters:
LEN, 16, number of characters in the target text (1..256).
IDX_W, 8, width of the position counter; must satisfy 2**IDX_W >= LEN.
ERR_HOLD, 50_000_000, cycles err_flash stays high after a wrong key (1 s at 50 MHz); minimum 1.

Ports:
clk  input  1  system clock, all logic on the rising edge.
rst  input  1  asynchronous, active-high reset.
key_code  input  8  decoded scan code of a released key; 8'h00 means unsupported key.
key_stb  input  1  one-cycle pulse qualifying key_code.
set_in  input  1  level from decoder, session start request; may stay high for several cycles.
reset_in  input  1  level from decoder, session abort request; may stay high for several cycles.
target_code  output  8  scan code expected at the current position.
pos  output  IDX_W  index of the current character.
err_cnt  output  8  number of wrong keys this session, saturating at 255.
err_flash  output  1  high while the error indication is shown.
busy  output  1  high in WAIT_KEY and ERR_SHOW.
done  output  1  high once the whole text is typed; held until the next set or reset.

Behaviour:
- Reset (rst=1, async): state IDLE; pos=0, err_cnt=0, err_flash=0, busy=0, done=0, edge-detect registers=0. target_code = table[0].
- set_in and reset_in are edge-detected with one register each. Only a 0->1 transition is an event, so a multi-cycle high counts once.
- States:
  - IDLE: set event -> WAIT_KEY; pos=0, err_cnt=0, done=0.
  - WAIT_KEY: busy=1. On key_stb with key_code==0: ignore.
    - key_code==target_code and pos==LEN-1 -> DONE, done=1, pos unchanged.
    - key_code==target_code otherwise -> pos+1, stay in WAIT_KEY.
    - key_code!=target_code -> err_cnt+1 (saturate at 255); load hold counter with ERR_HOLD-1; err_flash=1; go to ERR_SHOW.
  - ERR_SHOW: busy=1. key_stb is ignored, with no error counted. Hold counter decrements each cycle. When it reaches 0: err_flash=0 and return to WAIT_KEY. The flash lasts exactly ERR_HOLD cycles.
  - DONE: busy=0, done=1, pos and err_cnt frozen. Set event -> WAIT_KEY with counters cleared, as from IDLE.
- A set event in WAIT_KEY or ERR_SHOW is ignored; a session is not restarted mid-run.
- A reset event in any state -> IDLE next cycle: pos=0, err_cnt=0, err_flash=0, done=0, hold counter=0.
- Same-cycle priority: reset event > set event > key_stb.
- Latency: registered outputs (pos, err_cnt, err_flash, done, busy) change on the clock edge that samples key_stb or the edge-detected event, i.e. visible 1 cycle after the input. target_code is combinational from pos, so it follows pos in the same cycle.
- key_stb arriving in IDLE or DONE is ignored.
- No wrap-around: pos never exceeds LEN-1.

Decomposition:
- Shared package trainer_pkg holds:
  - the state encoding constants (IDLE, WAIT_KEY, ERR_SHOW, DONE);
  - the released-key marker 8'hF0, and the space/tab/right-shift codes 8'h29/8'h0D/8'h59;
  - the TRAINER_TEXT constant array of scan codes; entries 0..3 are 8'h15 q, 8'h1D w, 8'h24 e, 8'h2D r.
- One sub-module, trainer_text_rom: combinational lookup of pos -> target_code over TRAINER_TEXT, returning 8'h00 for pos >= LEN.

Test Plan:
- LEN=4, ERR_HOLD=3. Reset, pulse set_in for 5 cycles, then strobe 15,1D,24,2D -> pos steps 0..3; done=1 one cycle after the 4th strobe; err_cnt=0; busy=0; a second set edge restarts only once.
- In WAIT_KEY at pos=1 (target 1D), strobe 24 -> err_cnt=1; err_flash high exactly 3 cycles; a strobe of 1D during the flash is ignored (pos stays 1); after the flash, strobe 1D -> pos=2.
- Strobe key_code=00 in WAIT_KEY -> pos, err_cnt and state unchanged.
- Same cycle: reset_in rises together with set_in and key_stb=15, at pos=2 -> next cycle IDLE, pos=0, err_cnt=0, busy=0, done=0.
- Force 260 wrong keys with ERR_HOLD=1 -> err_cnt saturates at 255, no wrap to 0.
- Assert rst mid-ERR_SHOW, asynchronously between clock edges -> all outputs reach their reset values immediately, with no clock edge needed.
